// File: rtl/mbist_pkg.sv
// Shared state encoding and default sizing for the MBIST session sequencer.
// The state encodings are fixed because state_o is read by debug tooling.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN1 = 3'd1,
        ST_GAP  = 3'd2,
        ST_RUN2 = 3'd3,
        ST_DONE = 3'd4
    } mbist_state_e;

    localparam int DEF_MAX_REPAIRS    = 16;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 8192;

    // True while an MBIST pass is in flight and the watchdog is counting.
    function automatic logic is_running(input mbist_state_e s);
        return (s == ST_RUN1) || (s == ST_RUN2);
    endfunction

endpackage

// File: rtl/mbist_watchdog.sv
// Loadable down-counter used as the per-pass watchdog; one instance serves
// both MBIST passes and is reloaded with every bist_start.
module mbist_watchdog #(
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;

    // Load has priority so a reload on the same edge as a decrement wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(TIMEOUT_CYCLES);
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mbist_session_sequencer.sv
// Session controller: one start runs MBIST pass 1 (detect + repair map),
// a settle gap, then pass 2 (verify), and reports a registered verdict.
module mbist_session_sequencer
    import mbist_pkg::*;
#(
    parameter int MAX_REPAIRS    = DEF_MAX_REPAIRS,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(MAX_REPAIRS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             bist_start,
    input  logic             bist_done,
    input  logic             bist_fail,
    input  logic             bist_fail_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             repair_overflow,
    output logic [CNT_W-1:0] repair_count,
    output logic [2:0]       state_o
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_REPAIRS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_REPAIRS);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    mbist_state_e     state_q, state_d;
    logic             bist_start_q, bist_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             armed_q, armed_d;
    logic             vfail_q, vfail_d;

    logic             wd_load;
    logic             wd_expired;
    logic [CNT_W-1:0] cnt_inc;
    logic             done_ok;
    logic             vfail_now;

    mbist_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .enable  (is_running(state_q)),
        .expired (wd_expired)
    );

    // Handshake: start is a request honoured only in IDLE/DONE (ignored while
    // busy); bist_start is a one-cycle pulse; bist_done (level or pulse) only
    // completes a pass once it has been seen low since that pass's bist_start,
    // and done/pass/timeout stay valid until the next accepted start.
    always_comb begin
        state_d      = state_q;
        bist_start_d = 1'b0;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        armed_d      = armed_q;
        vfail_d      = vfail_q;
        wd_load      = 1'b0;

        cnt_inc   = (bist_fail_valid && (cnt_q != CNT_SAT)) ? cnt_q + 1'b1 : cnt_q;
        done_ok   = armed_q && bist_done;
        vfail_now = vfail_q || bist_fail_valid;

        if (is_running(state_q) && !bist_done) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN1;
                    bist_start_d = 1'b1;
                    wd_load      = 1'b1;
                    cnt_d        = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    ovf_d        = 1'b0;
                    armed_d      = 1'b0;
                    vfail_d      = 1'b0;
                end
            end
            ST_RUN1: begin
                cnt_d = cnt_inc;
                // The verdict uses the count including a same-cycle failure.
                if (done_ok) begin
                    if (cnt_inc == '0) begin
                        state_d = ST_DONE;
                        pass_d  = 1'b1;
                    end else if (cnt_inc > CNT_MAX) begin
                        state_d = ST_DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end else if (wd_expired) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d      = ST_RUN2;
                    bist_start_d = 1'b1;
                    wd_load      = 1'b1;
                    armed_d      = 1'b0;
                    vfail_d      = 1'b0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_RUN2: begin
                vfail_d = vfail_now;
                if (done_ok) begin
                    state_d = ST_DONE;
                    pass_d  = !bist_fail && !vfail_now;
                end else if (wd_expired) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN1) || (state_d == ST_GAP) || (state_d == ST_RUN2);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bist_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
            armed_q      <= 1'b0;
            vfail_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bist_start_q <= bist_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            armed_q      <= armed_d;
            vfail_q      <= vfail_d;
        end
    end

    assign bist_start      = bist_start_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign repair_overflow = ovf_q;
    assign repair_count    = cnt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mbist_session_sequencer.sv
// Bench for mbist_session_sequencer: a bench-side MBIST responder drives
// randomized sessions and a session-level model predicts each verdict.
module tb_mbist_session_sequencer;
    import mbist_pkg::*;

    localparam int MAX_R = DEF_MAX_REPAIRS;
    localparam int GAP   = DEF_GAP_CYCLES;
    localparam int TO    = DEF_TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_R + 2);
    localparam int VW    = CNT_W + 3;
    localparam int HANG  = 1 << 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             bist_start;
    logic             bist_done;
    logic             bist_fail;
    logic             bist_fail_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             repair_overflow;
    logic [CNT_W-1:0] repair_count;
    logic [2:0]       state_o;

    int               n_vec = 0;
    int               n_err = 0;
    int               n_starts = 0;
    int               hangs = 0;
    logic             done_prev = 1'b0;
    logic [VW-1:0]    exp_v;
    logic [VW-1:0]    exp_q[$];
    bit               fmask [0:4095];

    mbist_session_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .bist_start      (bist_start),
        .bist_done       (bist_done),
        .bist_fail       (bist_fail),
        .bist_fail_valid (bist_fail_valid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .repair_overflow (repair_overflow),
        .repair_count    (repair_count),
        .state_o         (state_o)
    );

    // Clock and run-time bound
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Session-level reference: verdict as {pass, timeout, overflow, count}.
    function automatic logic [VW-1:0] model_verdict(input int f1, input int len1,
                                                    input int f2, input int len2,
                                                    input bit fail2);
        int rc;
        bit p, t, o;
        rc = (f1 > MAX_R + 1) ? MAX_R + 1 : f1;
        p = 1'b0;
        t = 1'b0;
        o = 1'b0;
        if (len1 > TO)          t = 1'b1;
        else if (f1 == 0)       p = 1'b1;
        else if (f1 > MAX_R)    o = 1'b1;
        else if (len2 > TO)     t = 1'b1;
        else                    p = !fail2 && (f2 == 0);
        return {p, t, o, CNT_W'(rc)};
    endfunction

    function automatic bit model_two_passes(input int f1, input int len1);
        return (len1 <= TO) && (f1 >= 1) && (f1 <= MAX_R);
    endfunction

    // Scoreboard: every rising done pops one expected verdict.
    always @(negedge clk) begin
        if (bist_start === 1'b1) n_starts++;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", exp_q.size(), 1);
            end else begin
                exp_v = exp_q.pop_front();
                check_eq("verdict", {pass, timeout, repair_overflow, repair_count}, exp_v);
            end
        end
        done_prev = done;
    end

    // MBIST responder for one pass, entered at the negedge where bist_start is
    // seen (cycle 0). done is driven at cycle len; lat is the cycle the pass
    // was left (done seen, or cycle len+1 reached).
    task automatic play_pass(input int nf, input int len, input int stale,
                             input bit sticky, input bit poke,
                             output int lat, output bit saw_done);
        int c;
        int span;
        int placed;
        int pos;
        span = (len < 400) ? len : 400;
        for (int i = 0; i <= span; i++) fmask[i] = 1'b0;
        placed = 0;
        while (placed < nf) begin
            pos = $urandom_range(0, span);
            if (!fmask[pos]) begin
                fmask[pos] = 1'b1;
                placed++;
            end
        end
        c = 0;
        saw_done = 1'b0;
        forever begin
            if (c > 0 && done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
            if (c == len + 1 || c > TO + 20) break;
            bist_fail_valid = (c <= span) && fmask[c];
            bist_done       = (c == len) || (c < stale);
            bist_fail       = (c == len) && sticky;
            start           = poke && (c == len / 2);
            @(negedge clk);
            c++;
        end
        bist_fail_valid = 1'b0;
        bist_fail       = 1'b0;
        start           = 1'b0;
        if ($urandom_range(0, 1) == 0) bist_done = 1'b0;
        lat = c;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_session(input int f1, input int len1, input int f2, input int len2,
                               input bit fail2, input int s1, input int s2, input bit poke);
        bit two;
        int lat;
        bit seen;
        int g;
        int st0;
        two = model_two_passes(f1, len1);
        exp_q.push_back(model_verdict(f1, len1, f2, len2, fail2));
        @(negedge clk);
        #1 st0 = n_starts;
        pulse_start();
        check_eq("bist_start_lat", bist_start, 1);
        check_eq("busy_on_start", busy, 1);
        play_pass(f1, len1, s1, f1 > 0, poke, lat, seen);
        check_eq("pass1_len", lat, (len1 > TO) ? TO + 1 : len1 + 1);
        if (two) begin
            check_eq("gap_entry", state_o, ST_GAP);
            g = 0;
            for (int k = 0; k < 50 && bist_start !== 1'b1; k++) begin
                if (state_o == ST_GAP) g++;
                @(negedge clk);
            end
            check_eq("gap_cycles", g, GAP);
            check_eq("bist_start2", bist_start, 1);
            play_pass(f2, len2, s2, fail2, 1'b0, lat, seen);
            check_eq("pass2_len", lat, (len2 > TO) ? TO + 1 : len2 + 1);
        end
        check_eq("done_after", {done, busy}, 2'b10);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check_eq("done_held", {done, busy}, 2'b10);
        #1 check_eq("bist_starts", n_starts - st0, two ? 2 : 1);
    endtask

    task automatic reset_in_gap();
        int lat;
        bit seen;
        int st0;
        @(negedge clk);
        #1 st0 = n_starts;
        pulse_start();
        play_pass(3, 40, 0, 1'b1, 1'b0, lat, seen);
        check_eq("abort_gap_entry", state_o, ST_GAP);
        repeat (GAP - 1) @(negedge clk);
        check_eq("abort_last_gap", state_o, ST_GAP);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_state", state_o, ST_IDLE);
        check_eq("abort_outputs",
                 {bist_start, busy, done, pass, timeout, repair_overflow, repair_count}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1 check_eq("abort_no_restart", n_starts - st0, 1);
    endtask

    initial begin
        int f1, len1, f2, len2, s1, s2, cat;
        bit fail2, poke;
        rst             = 1'b1;
        start           = 1'b1;
        bist_done       = 1'b0;
        bist_fail       = 1'b0;
        bist_fail_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", state_o, ST_IDLE);
        check_eq("rst_bist_start", bist_start, 0);
        check_eq("rst_flags", {busy, done, pass, timeout, repair_overflow}, 0);
        check_eq("rst_count", repair_count, 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_state", state_o, ST_IDLE);

        run_session(0, 2600, 0, 0, 1'b0, 0, 0, 1'b0);          // clean memory
        run_session(3, 120, 0, 80, 1'b0, 0, 0, 1'b0);          // three repairs
        run_session(17, 150, 0, 0, 1'b0, 0, 0, 1'b0);          // overflow
        run_session(2, 100, 0, 90, 1'b1, 0, 0, 1'b0);          // repair ineffective
        run_session(2, HANG, 0, 0, 1'b0, 0, 0, 1'b0);          // hang in pass 1
        run_session(1, 50, 0, HANG, 1'b0, 0, 0, 1'b0);         // hang in pass 2
        run_session(0, 200, 0, 0, 1'b0, 40, 0, 1'b0);          // stale done at start
        run_session(3, 100, 0, 60, 1'b0, 0, 0, 1'b1);          // start during RUN1
        run_session(0, TO, 0, 0, 1'b0, 0, 0, 1'b0);            // done meets expiry
        run_session(0, TO + 1, 0, 0, 1'b0, 0, 0, 1'b0);        // done one late
        reset_in_gap();

        for (int i = 0; i < 24; i++) begin
            cat   = $urandom_range(0, 9);
            f1    = (cat < 2) ? 0 :
                    (cat < 4) ? $urandom_range(MAX_R + 1, MAX_R + 4) : $urandom_range(1, MAX_R);
            len1  = $urandom_range(f1 + 10, f1 + 300);
            f2    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            len2  = $urandom_range(10, 300);
            fail2 = ($urandom_range(0, 3) == 0);
            s1    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : 0;
            s2    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : 0;
            poke  = ($urandom_range(0, 3) == 0);
            if (hangs < 1 && $urandom_range(0, 15) == 0) begin
                len2 = HANG;
                hangs++;
            end
            run_session(f1, len1, f2, len2, fail2, s1, s2, poke);
        end

        repeat (2) @(negedge clk);
        check_eq("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
